pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage LC-3b pipeline (IF, ID, EX, MEM, WB). It drives every pipeline-register load enable and bubble/flush strobe.
- It covers I-cache and D-cache waits, the two-access LDI/STI sequence in MEM, load-use bubbles that the forwarding logic cannot cover, and branch redirects resolved in MEM.
- It keeps free-running stall and flush counters for performance measurement.

Parameters:
CNT_W, 16, width of the performance counters (wrap on overflow)

Ports:
clk  in  1  pipeline clock
reset_n  in  1  asynchronous active-low reset
imem_read  in  1  IF stage has an I-cache request outstanding
imem_resp  in  1  I-cache returns the instruction this cycle
id_valid  in  1  IF/ID holds a real (non-bubble) instruction
id_sr1  in  lc3b_reg  ID source register 1
id_sr2  in  lc3b_reg  ID source register 2
id_sr2_used  in  1  ID reads sr2 (register form, or the store source)
exec_mem_read  in  1  EX instruction is LDR/LDB/LDI
exec_dest  in  lc3b_reg  EX destination register
mem_access  in  1  MEM instruction uses the D-cache
mem_opcode  in  lc3b_opcode  MEM opcode
dmem_resp  in  1  D-cache completes the current access
branch_taken  in  1  MEM resolved a taken BR/JMP/JSR/TRAP
load_pc  out  1  PC register enable
load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1 each  stage register enables
flush_if_id, flush_id_ex, flush_ex_mem  out  1 each  load a NOP bubble instead of upstream data
indirect_phase  out  1  MEM is on the second LDI/STI access; address comes from MDR
stall_cycles  out  CNT_W  cycles in which any stage was frozen
flush_count  out  CNT_W  branch redirects taken

Behaviour:
D-cache sequencer (registered FSM, states MS_FIRST and MS_SECOND):
- Reset state is MS_FIRST.
- MS_FIRST: on mem_access & dmem_resp, go to MS_SECOND if mem_opcode is op_ldi or op_sti; otherwise stay.
- MS_SECOND: on dmem_resp, return to MS_FIRST.
- indirect_phase = (state == MS_SECOND).
- mem_stall = mem_access & ~(dmem_resp & (state==MS_SECOND | mem_opcode not ldi/sti)).
- An LDI/STI therefore needs at least two dmem_resp pulses; it never completes in MS_FIRST.

Combinational priority, highest first:
1. mem_stall:
   - All load_* = 0 and all flush_* = 0.
   - The whole pipe freezes, including WB, so forwarding sources stay stable.
2. branch_taken (MEM not stalled):
   - load_pc = 1; all stage loads = 1.
   - flush_if_id = flush_id_ex = flush_ex_mem = 1.
   - An outstanding imem_read is abandoned. The I-cache tolerates an address change.
3. load_use = id_valid & exec_mem_read & (exec_dest==id_sr1 | (id_sr2_used & exec_dest==id_sr2)):
   - load_pc = 0, load_if_id = 0.
   - load_id_ex = 1 with flush_id_ex = 1; load_ex_mem = load_mem_wb = 1.
   - Exactly one bubble per hazard. Next cycle the load is in MEM and normal forwarding resolves the dependency.
4. imem stall (imem_read & ~imem_resp):
   - load_pc = 0; load_if_id = 1 with flush_if_id = 1.
   - Downstream stages advance.
5. Otherwise all load_* = 1 and all flush_* = 0.

Simultaneous events:
- load_use together with an imem stall: the load_use rule applies, and IF/ID holds its content (it does not take a bubble).

Counters:
- stall_cycles increments on any cycle where mem_stall, load_use or the imem stall is active and branch_taken does not win.
- flush_count increments on cycles where rule 2 applies.
- Both counters wrap modulo 2^CNT_W.

Reset:
- reset_n low asynchronously forces MS_FIRST and zeroes both counters.
- Combinational outputs follow their inputs. With all inputs 0 after reset: every load_* = 1, every flush_* = 0, indirect_phase = 0.
- Reset during MS_SECOND abandons the indirect access; the D-cache is reset by the same signal.

Decomposition:
- Add to lc3b_types: the enum mem_seq_state_t {MS_FIRST, MS_SECOND}, and a function is_indirect(lc3b_opcode) returning 1 for op_ldi/op_sti.
- Sub-module dmem_sequencer holds the FSM and produces mem_stall and indirect_phase.

Test Plan:
- LDR in MEM, dmem_resp held low 3 cycles then pulsed -> all loads 0 for 3 cycles, then all 1; stall_cycles = 3.
- LDI in MEM, dmem_resp pulsed on cycles 2 and 5 -> indirect_phase high on cycles 3-5; pipe frozen cycles 1-4; state back to MS_FIRST after cycle 5.
- EX = LDR R3, ID = ADD R1,R3,R2 with id_sr2_used = 1 -> one cycle with load_pc = 0, load_if_id = 0, flush_id_ex = 1; next cycle no stall.
- EX = LDR R3, ID = ADD R1,R2,#5 (sr2 field = R3, id_sr2_used = 0) -> no bubble.
- branch_taken with imem stall pending -> load_pc = 1, three flushes; flush_count goes 0 to 1.
- Assert reset_n mid-LDI (MS_SECOND) -> indirect_phase = 0 immediately; counters = 0.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: register indices, opcodes and the D-cache sequencer state.
package lc3b_types;

    typedef logic [2:0] lc3b_reg;

    typedef enum logic [3:0] {
        op_br   = 4'd0,
        op_add  = 4'd1,
        op_ldb  = 4'd2,
        op_stb  = 4'd3,
        op_jsr  = 4'd4,
        op_and  = 4'd5,
        op_ldr  = 4'd6,
        op_str  = 4'd7,
        op_rti  = 4'd8,
        op_not  = 4'd9,
        op_ldi  = 4'd10,
        op_sti  = 4'd11,
        op_jmp  = 4'd12,
        op_shf  = 4'd13,
        op_lea  = 4'd14,
        op_trap = 4'd15
    } lc3b_opcode;

    typedef enum logic {
        MS_FIRST  = 1'b0,
        MS_SECOND = 1'b1
    } mem_seq_state_t;

    // LDI/STI take two D-cache accesses: pointer fetch, then the real access.
    function automatic logic is_indirect(input lc3b_opcode op);
        return (op == op_ldi) || (op == op_sti);
    endfunction

endpackage

// File: rtl/dmem_sequencer.sv
// Tracks which D-cache access of an LDI/STI the MEM stage is on and
// reports when MEM must hold the pipe.
module dmem_sequencer
    import lc3b_types::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       mem_access,
    input  lc3b_opcode mem_opcode,
    input  logic       dmem_resp,
    output logic       mem_stall,
    output logic       indirect_phase
);

    mem_seq_state_t state_q, state_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= MS_FIRST;
        end else begin
            state_q <= state_d;
        end
    end

    // A response in MS_FIRST only finishes the instruction if it is not indirect.
    always_comb begin
        state_d        = state_q;
        mem_stall      = 1'b0;
        indirect_phase = 1'b0;
        case (state_q)
            MS_FIRST: begin
                if (mem_access && dmem_resp && is_indirect(mem_opcode)) begin
                    state_d = MS_SECOND;
                end
                mem_stall = mem_access && !(dmem_resp && !is_indirect(mem_opcode));
            end
            MS_SECOND: begin
                indirect_phase = 1'b1;
                if (dmem_resp) begin
                    state_d = MS_FIRST;
                end
                mem_stall = mem_access && !dmem_resp;
            end
            default: begin
                state_d = MS_FIRST;
            end
        endcase
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage LC-3b pipeline: drives every stage
// register enable and bubble strobe, and counts stall and redirect cycles.
module pipeline_hazard_ctrl
    import lc3b_types::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             imem_read,
    input  logic             imem_resp,
    input  logic             id_valid,
    input  lc3b_reg          id_sr1,
    input  lc3b_reg          id_sr2,
    input  logic             id_sr2_used,
    input  logic             exec_mem_read,
    input  lc3b_reg          exec_dest,
    input  logic             mem_access,
    input  lc3b_opcode       mem_opcode,
    input  logic             dmem_resp,
    input  logic             branch_taken,
    output logic             load_pc,
    output logic             load_if_id,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic             indirect_phase,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    logic             mem_stall;
    logic             load_use;
    logic             imem_stall;
    logic             stall_event;
    logic             redirect;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    dmem_sequencer u_dmem_sequencer (
        .clk            (clk),
        .reset_n        (reset_n),
        .mem_access     (mem_access),
        .mem_opcode     (mem_opcode),
        .dmem_resp      (dmem_resp),
        .mem_stall      (mem_stall),
        .indirect_phase (indirect_phase)
    );

    assign load_use   = id_valid && exec_mem_read &&
                        ((exec_dest == id_sr1) || (id_sr2_used && (exec_dest == id_sr2)));
    assign imem_stall = imem_read && !imem_resp;

    // A MEM stall freezes everything including WB so forwarding sources hold still.
    always_comb begin
        load_pc      = 1'b1;
        load_if_id   = 1'b1;
        load_id_ex   = 1'b1;
        load_ex_mem  = 1'b1;
        load_mem_wb  = 1'b1;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        redirect     = 1'b0;
        stall_event  = 1'b0;
        if (mem_stall) begin
            load_pc     = 1'b0;
            load_if_id  = 1'b0;
            load_id_ex  = 1'b0;
            load_ex_mem = 1'b0;
            load_mem_wb = 1'b0;
            stall_event = 1'b1;
        end else if (branch_taken) begin
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
            redirect     = 1'b1;
        end else if (load_use) begin
            load_pc     = 1'b0;
            load_if_id  = 1'b0;
            flush_id_ex = 1'b1;
            stall_event = 1'b1;
        end else if (imem_stall) begin
            load_pc     = 1'b0;
            flush_if_id = 1'b1;
            stall_event = 1'b1;
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q + CNT_W'(stall_event);
        flush_count_d  = flush_count_q + CNT_W'(redirect);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;

endmodule
